// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus registered output stream used by the burst reader.
// master = burst reader side, slave = FIFO/consumer side.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_r_en, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_r_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a requested number of words from a show-ahead FIFO and replays them
// on a registered valid/ready stream, with a done pulse after the last beat.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    fifo_burst_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state_q;
    state_t                state_d;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  pop;
    logic                  done_d;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  last_p1;

    // A pop needs a word left to fetch, a word in the FIFO and a free output slot.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        pop     = !rst_n && (state_q == READ) && (remaining != '0) &&
                  !bus.fifo_empty && (!vld_p1 || bus.out_ready);
        unique case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = READ;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            READ: begin
                if (pop && (remaining == LEN_ONE)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (vld_p1 && bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: output register fed directly from the FIFO head.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            remaining <= '0;
            done_q    <= 1'b0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if ((state_q == IDLE) && start && (len != '0)) begin
                remaining <= len;
            end
            if (pop) begin
                data_p1   <= bus.fifo_data;
                vld_p1    <= 1'b1;
                last_p1   <= (remaining == LEN_ONE);
                remaining <= remaining - LEN_ONE;
            end else if (vld_p1 && bus.out_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign bus.fifo_r_en = pop;
    assign bus.out_data  = data_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, directed and random
// bursts, scoreboard monitor comparing the stream against FIFO push order.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len   = '0;
    logic          busy;
    logic          done;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bif();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: pushes requested by stimulus, pops decided by the monitor.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] push_req[$];
    logic [DW-1:0] pushed_log[$];
    bit            clear_req   = 1'b0;
    bit            pop_pending = 1'b0;

    initial begin : fifo_model
        bif.fifo_empty = 1'b1;
        bif.fifo_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #2;
            if (clear_req) begin
                fifo_q.delete();
                clear_req = 1'b0;
            end
            foreach (push_req[i]) begin
                fifo_q.push_back(push_req[i]);
                pushed_log.push_back(push_req[i]);
            end
            push_req.delete();
            bif.fifo_empty = (fifo_q.size() == 0);
            bif.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Scoreboard monitor: delivered words must follow FIFO push order, bursts
    // are tracked by length only.
    int            rd_idx     = 0;
    int            burst_q[$];
    int            beat_cnt   = 0;
    int            pops_left  = 0;
    int            beats_seen = 0;
    bit            busy_m     = 1'b0;
    bit            done_due   = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    initial begin : monitor
        bit was_busy;
        bit new_done;
        bit exp_last;
        bit want_pop;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rst_out_valid", bif.out_valid, 0);
                check("rst_fifo_r_en", bif.fifo_r_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                burst_q.delete();
                beat_cnt    = 0;
                pops_left   = 0;
                busy_m      = 1'b0;
                done_due    = 1'b0;
                prev_stall  = 1'b0;
                pop_pending = 1'b0;
                rd_idx      = pushed_log.size();
            end else begin
                was_busy = busy_m;
                new_done = 1'b0;
                check("done", done, done_due);
                check("busy", busy, busy_m);
                if (prev_stall) begin
                    check("stall_valid", bif.out_valid, 1);
                    check("stall_data", bif.out_data, prev_data);
                    check("stall_last", bif.out_last, prev_last);
                end
                want_pop = busy_m && (pops_left > 0) && !bif.fifo_empty &&
                           (!bif.out_valid || bif.out_ready);
                check("fifo_r_en", bif.fifo_r_en, want_pop);
                if (bif.fifo_r_en) begin
                    check("pop_budget", pops_left > 0, 1);
                    if (pops_left > 0) pops_left--;
                end
                pop_pending = bif.fifo_r_en && !bif.fifo_empty;
                if (bif.out_valid && bif.out_ready) begin
                    if (rd_idx < pushed_log.size()) begin
                        check("out_data", bif.out_data, pushed_log[rd_idx]);
                    end else begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_data: beat 0x%0h delivered, no pushed word expected", bif.out_data);
                    end
                    rd_idx++;
                    beats_seen++;
                    if (burst_q.size() > 0) begin
                        exp_last = (beat_cnt == burst_q[0] - 1);
                        check("out_last", bif.out_last, exp_last);
                        beat_cnt++;
                        if (exp_last) begin
                            void'(burst_q.pop_front());
                            beat_cnt = 0;
                            new_done = 1'b1;
                            busy_m   = 1'b0;
                        end
                    end else begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL beat_outside_burst: got beat 0x%0h, expected none", bif.out_data);
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = bif.out_valid;
                    prev_data  = bif.out_data;
                    prev_last  = bif.out_last;
                end
                if (start && !was_busy) begin
                    if (len == '0) begin
                        new_done = 1'b1;
                    end else begin
                        burst_q.push_back(int'(len));
                        busy_m    = 1'b1;
                        pops_left = int'(len);
                    end
                end
                done_due = new_done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] d);
        push_req.push_back(d);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cycles;
        int base;
        bif.out_ready = 1'b0;
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("rst_out_data", bif.out_data, 0);
        check("rst_out_last", bif.out_last, 0);
        rst_n = 1'b0;
        tick();

        // Preloaded FIFO, full-rate burst of 4.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick();
        bif.out_ready = 1'b1;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        check("t1_cycles_to_done", cycles, 5);
        tick();
        check("t1_fifo_left", fifo_q.size(), 0);

        // Partial read: 3 of 6 words.
        for (int i = 0; i < 6; i++) push(DW'($urandom));
        tick();
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        wait_idle("t2_idle", 30);
        repeat (3) tick();
        check("t2_fifo_left", fifo_q.size(), 3);

        // Consumer back-pressure pattern 1,0,0,1.
        push(DW'($urandom));
        tick();
        base = beats_seen;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bif.out_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        check("t3_beats", beats_seen - base, 4);
        check("t3_busy", busy, 0);
        check("t3_fifo_left", fifo_q.size(), 0);

        // Empty FIFO at start, words trickle in.
        bif.out_ready = 1'b1;
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        push(8'hA5);
        tick();
        check("t4_valid_a5", bif.out_valid, 1);
        check("t4_data_a5", bif.out_data, 8'hA5);
        repeat (3) begin
            tick();
            check("t4_busy_wait", busy, 1);
        end
        push(8'h5A);
        tick();
        check("t4_valid_5a", bif.out_valid, 1);
        check("t4_data_5a", bif.out_data, 8'h5A);
        wait_idle("t4_idle", 10);

        // Zero-length burst, then start while busy.
        tick();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        check("t5_len0_done", done, 1);
        check("t5_len0_busy", busy, 0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick();
        start = 1'b1; len = 8'd2;
        tick();
        len = 8'd5;
        repeat (2) tick();
        start = 1'b0;
        wait_idle("t5_idle", 20);
        repeat (2) tick();
        check("t5_fifo_left", fifo_q.size(), 2);

        // Reset in the middle of a 5-word burst.
        push(8'hC1); push(8'hC2); push(8'hC3);
        tick();
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        base = beats_seen;
        cycles = 0;
        while (beats_seen < base + 2 && cycles < 20) begin
            tick();
            cycles++;
        end
        check("t6_two_beats", beats_seen - base, 2);
        rst_n = 1'b1;
        clear_req = 1'b1;
        #1;
        check("t6_rst_valid", bif.out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_r_en", bif.fifo_r_en, 0);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        tick();
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        wait_idle("t6_idle", 20);
        repeat (2) tick();
        check("t6_fifo_left", fifo_q.size(), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bif.out_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() + push_req.size() < 10 && $urandom_range(0, 1) == 1)
                push(DW'($urandom));
            start = ($urandom_range(0, 3) == 0);
            len = LW'($urandom_range(0, 6));
            tick();
        end
        start = 1'b0;
        bif.out_ready = 1'b1;
        cycles = 0;
        while (busy && cycles < 200) begin
            if (fifo_q.size() == 0 && push_req.size() == 0) push(DW'($urandom));
            tick();
            cycles++;
        end
        check("rand_drained", busy, 0);
        repeat (3) tick();
        check("rand_leftover", pushed_log.size() - rd_idx, fifo_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the synchronous FIFO.
- On a start command it pops exactly `len` words from a show-ahead FIFO read port.
- Popped words are presented on a registered valid/ready stream toward the systolic array edge, and a done pulse follows the final beat.
- Throughput is one word per cycle while the FIFO is non-empty and the consumer is ready.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
LEN_WIDTH, 8, width of burst length; max burst = 2^LEN_WIDTH-1 words

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-high reset (asserted = 1, despite the suffix)
start  input  1  burst request, sampled only in IDLE
len  input  LEN_WIDTH  burst length, sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at burst completion
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO head word (show-ahead, valid when !fifo_empty)
fifo_r_en  output  1  FIFO pop; the pop takes effect at the edge where fifo_r_en & !fifo_empty
out_data  output  DATA_WIDTH  stream data (registered)
out_valid  output  1  stream valid (registered)
out_ready  input  1  consumer ready
out_last  output  1  marks final beat of burst, qualified by out_valid

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE, remaining=0.
  - out_valid=0, out_last=0, out_data=0, done=0, busy=0.
  - fifo_r_en=0 for the whole time reset is asserted.
  - Reset mid-burst abandons the burst without a done pulse. FIFO contents are not touched by this block.
- States:
  - IDLE: busy=0, fifo_r_en=0.
    - start=1 with len!=0: remaining<=len, go READ.
    - start=1 with len==0: stay IDLE, done=1 in the next cycle.
  - READ: pop = (remaining!=0) & !fifo_empty & (!out_valid | out_ready). fifo_r_en = pop (combinational from out_ready and fifo_empty).
    - On pop: out_data<=fifo_data, out_valid<=1, out_last<=(remaining==1), remaining<=remaining-1.
    - Pop with remaining==1: go FLUSH.
    - No pop while out_valid & out_ready: out_valid<=0, out_last<=0.
  - FLUSH: fifo_r_en=0.
    - On out_valid & out_ready: out_valid<=0, out_last<=0, done<=1 (high exactly one cycle after that edge), go IDLE.
- start is ignored while busy. len is only sampled in IDLE.
- Latency: the word popped at edge N appears on out_data/out_valid after edge N.
- Back-to-back handshakes sustain one beat per clock.
- Stream stability: while out_valid=1 & out_ready=0, out_data/out_last hold and no pop occurs.
- FIFO empty mid-burst: no pop, remaining holds. The current out beat may still complete, which drops out_valid. Reading resumes on the first non-empty cycle.
- Exactly len pops per burst, never more. fifo_r_en is never asserted when remaining==0.
- done: registered, one-cycle pulse. busy drops in the same cycle done rises. A new start is accepted in that cycle (state is IDLE).
- remaining is LEN_WIDTH bits and never underflows.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44; start len=4, out_ready=1 -> beats 0x11..0x44 on 4 consecutive cycles; out_last only on 0x44; done pulse 1 cycle later; FIFO empty afterward.
- FIFO holds 6 words, start len=3 -> exactly 3 pops, remaining FIFO count 3, fifo_r_en never high after the third pop.
- len=4 with out_ready toggling 1,0,0,1,... -> out_data stable across every stall; no pop while out_valid=1 & out_ready=0; all 4 words delivered in order.
- FIFO initially empty, start len=2, push 0xA5 at cycle 5 and 0x5A at cycle 9 -> each beat appears the cycle after its push; busy stays high throughout; done after 0x5A is accepted.
- start len=0 -> no fifo_r_en, done pulse next cycle, busy never high. start while busy -> ignored, burst count unchanged.
- Assert rst_n mid-burst after 2 of 5 beats -> out_valid=0, busy=0, fifo_r_en=0 immediately, no done; a new start len=3 after release pops exactly 3 words.
